// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point radix-2 DIT FFT issue controller.
//   - controller state encoding
//   - fp32 twiddle constants W8^0..W8^3
//   - bitrev3() used to scatter natural-order input into the working buffer
//   - bf_req_t: one registered butterfly request (addresses, operands, twiddle)
package fft_pkg;

    localparam int N      = 8;
    localparam int STAGES = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_e;

    // W8^t = exp(-j*2*pi*t/8), fp32
    localparam logic [31:0] W0_RE = 32'h3F80_0000;
    localparam logic [31:0] W0_IM = 32'h0000_0000;
    localparam logic [31:0] W1_RE = 32'h3F35_04F3;
    localparam logic [31:0] W1_IM = 32'hBF35_04F3;
    localparam logic [31:0] W2_RE = 32'h0000_0000;
    localparam logic [31:0] W2_IM = 32'hBF80_0000;
    localparam logic [31:0] W3_RE = 32'hBF35_04F3;
    localparam logic [31:0] W3_IM = 32'hBF35_04F3;

    typedef struct packed {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [31:0] ar;
        logic [31:0] ai;
        logic [31:0] br;
        logic [31:0] bi;
        logic [31:0] w_re;
        logic [31:0] w_im;
        logic        is_mj;
    } bf_req_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    function automatic logic [31:0] tw_re(input logic [1:0] t);
        case (t)
            2'd0:    return W0_RE;
            2'd1:    return W1_RE;
            2'd2:    return W2_RE;
            default: return W3_RE;
        endcase
    endfunction

    function automatic logic [31:0] tw_im(input logic [1:0] t);
        case (t)
            2'd0:    return W0_IM;
            2'd1:    return W1_IM;
            2'd2:    return W2_IM;
            default: return W3_IM;
        endcase
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address/twiddle generator for an 8-point radix-2 DIT FFT.
// Purely combinational: (stage, k) -> operand addresses a/b, twiddle index t,
// and a flag for the t=2 (-j) twiddle.
//   stage : 0..2, butterfly stage
//   k     : 0..3, butterfly within the stage
//   a, b  : working-buffer addresses, b = a + 2^stage
//   t     : twiddle index into W8^t
//   is_mj : twiddle is exactly -j
module fft_addr_gen (
    input  logic [1:0] stage,
    input  logic [1:0] k,
    output logic [2:0] a,
    output logic [2:0] b,
    output logic [1:0] t,
    output logic       is_mj
);

    logic [2:0] k3;
    logic [2:0] half;
    logic [2:0] mask;

    always_comb begin
        k3   = {1'b0, k};
        half = 3'd1 << stage;
        mask = half - 3'd1;
        // Upper bits of k pick the group (stride 2*half), lower bits the offset within it.
        a     = ((k3 >> stage) << (stage + 2'd1)) | (k3 & mask);
        b     = a + half;
        t     = 2'((k3 & mask) << (2'd2 - stage));
        is_mj = (t == 2'd2);
    end

endmodule

// File: rtl/fft_issue_ctrl.sv
// Initiator side of the butterfly issue/writeback interface for an 8-point
// fp32 FFT. Loads 8 samples into a bit-reversed working buffer, issues the
// 3 DIT stages (4 butterflies each) to an external butterfly unit, absorbs
// its writebacks behind a per-stage barrier, then streams X[0..7] out.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    begin a frame (IDLE only)
//   in_valid/in_ready/in_*   natural-order input samples x[0..7]
//   bf_issue, bf_*           registered one-cycle butterfly request
//   bf_wb_*                  butterfly results, written to buf[a] and buf[b]
//   out_valid/out_ready/out_* natural-order output X[0..7]
//   busy, done, err          status; err is a sticky drain timeout
module fft_issue_ctrl
    import fft_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_re,
    input  logic [31:0] in_im,
    output logic        bf_issue,
    output logic [2:0]  bf_a_now,
    output logic [2:0]  bf_b_now,
    output logic [31:0] bf_ar,
    output logic [31:0] bf_ai,
    output logic [31:0] bf_br,
    output logic [31:0] bf_bi,
    output logic [31:0] bf_w_re,
    output logic [31:0] bf_w_im,
    output logic        bf_is_mj,
    input  logic        bf_wb_valid,
    input  logic [2:0]  bf_wb_addr_a,
    input  logic [2:0]  bf_wb_addr_b,
    input  logic [31:0] bf_wb_re_a,
    input  logic [31:0] bf_wb_im_a,
    input  logic [31:0] bf_wb_re_b,
    input  logic [31:0] bf_wb_im_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_idx,
    output logic [31:0] out_re,
    output logic [31:0] out_im,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic [N-1:0][31:0]     buf_re_q, buf_re_d;
    logic [N-1:0][31:0]     buf_im_q, buf_im_d;
    logic [2:0]             n_q, n_d;
    logic [1:0]             stage_q, stage_d;
    logic [1:0]             k_q, k_d;
    logic [CNT_W-1:0]       outst_q, outst_d;
    logic [TO_W-1:0]        drain_cnt_q, drain_cnt_d;
    logic [2:0]             out_idx_q, out_idx_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   bf_issue_q, bf_issue_d;
    bf_req_t                bf_q, bf_d;

    logic [2:0]             ag_a, ag_b;
    logic [1:0]             ag_t;
    logic                   ag_is_mj;
    logic                   issue_now;
    logic                   wb_ok;

    fft_addr_gen u_addr_gen (
        .stage (stage_q),
        .k     (k_q),
        .a     (ag_a),
        .b     (ag_b),
        .t     (ag_t),
        .is_mj (ag_is_mj)
    );

    assign issue_now = (state_q == S_ISSUE);
    // Writebacks only land while a stage is in flight; stray ones elsewhere are dropped.
    assign wb_ok     = bf_wb_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

    always_comb begin
        state_d     = state_q;
        buf_re_d    = buf_re_q;
        buf_im_d    = buf_im_q;
        n_d         = n_q;
        stage_d     = stage_q;
        k_d         = k_q;
        outst_d     = outst_q;
        drain_cnt_d = drain_cnt_q;
        out_idx_d   = out_idx_q;
        err_d       = err_q;
        done_d      = 1'b0;
        bf_issue_d  = 1'b0;
        bf_d        = bf_q;

        // Issue and writeback in the same cycle cancel out.
        if (issue_now && !wb_ok) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!issue_now && wb_ok && (outst_q != '0)) begin
            outst_d = outst_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    n_d     = 3'd0;
                    err_d   = 1'b0;
                    // A timed-out frame can leave the counter non-zero.
                    outst_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    buf_re_d[bitrev3(n_q)] = in_re;
                    buf_im_d[bitrev3(n_q)] = in_im;
                    n_d = n_q + 3'd1;
                    if (n_q == 3'd7) begin
                        state_d = S_ISSUE;
                        stage_d = 2'd0;
                        k_d     = 2'd0;
                    end
                end
            end
            S_ISSUE: begin
                // Butterflies within a stage touch disjoint addresses, so reading
                // the buffer here cannot race a same-stage writeback.
                bf_issue_d = 1'b1;
                bf_d.a     = ag_a;
                bf_d.b     = ag_b;
                bf_d.ar    = buf_re_q[ag_a];
                bf_d.ai    = buf_im_q[ag_a];
                bf_d.br    = buf_re_q[ag_b];
                bf_d.bi    = buf_im_q[ag_b];
                bf_d.w_re  = tw_re(ag_t);
                bf_d.w_im  = tw_im(ag_t);
                bf_d.is_mj = ag_is_mj;
                k_d        = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                // Stage barrier: next stage reads what this stage writes.
                if (outst_q == '0) begin
                    if (stage_q == 2'(STAGES - 1)) begin
                        state_d   = S_OUT;
                        out_idx_d = 3'd0;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 2'd1;
                        k_d     = 2'd0;
                    end
                end else if (drain_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + TO_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_idx_d = out_idx_q + 3'd1;
                    if (out_idx_q == 3'd7) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wb_ok) begin
            buf_re_d[bf_wb_addr_a] = bf_wb_re_a;
            buf_im_d[bf_wb_addr_a] = bf_wb_im_a;
            buf_re_d[bf_wb_addr_b] = bf_wb_re_b;
            buf_im_d[bf_wb_addr_b] = bf_wb_im_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_re_q    <= '0;
            buf_im_q    <= '0;
            n_q         <= '0;
            stage_q     <= '0;
            k_q         <= '0;
            outst_q     <= '0;
            drain_cnt_q <= '0;
            out_idx_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            bf_issue_q  <= 1'b0;
            bf_q        <= '0;
        end else begin
            state_q     <= state_d;
            buf_re_q    <= buf_re_d;
            buf_im_q    <= buf_im_d;
            n_q         <= n_d;
            stage_q     <= stage_d;
            k_q         <= k_d;
            outst_q     <= outst_d;
            drain_cnt_q <= drain_cnt_d;
            out_idx_q   <= out_idx_d;
            err_q       <= err_d;
            done_q      <= done_d;
            bf_issue_q  <= bf_issue_d;
            bf_q        <= bf_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_idx   = out_valid ? out_idx_q : 3'd0;
    assign out_re    = out_valid ? buf_re_q[out_idx_q] : 32'd0;
    assign out_im    = out_valid ? buf_im_q[out_idx_q] : 32'd0;
    assign done      = done_q;
    assign err       = err_q;

    assign bf_issue  = bf_issue_q;
    assign bf_a_now  = bf_q.a;
    assign bf_b_now  = bf_q.b;
    assign bf_ar     = bf_q.ar;
    assign bf_ai     = bf_q.ai;
    assign bf_br     = bf_q.br;
    assign bf_bi     = bf_q.bi;
    assign bf_w_re   = bf_q.w_re;
    assign bf_w_im   = bf_q.w_im;
    assign bf_is_mj  = bf_q.is_mj;

endmodule

// File: tb/tb_fft_issue_ctrl.sv
// Bench for fft_issue_ctrl: a butterfly-unit model answers issues after a
// short latency; directed frames are checked against hand-computed spectra,
// the issue order/twiddles, the stage barrier, output stall, drain timeout
// and mid-frame reset.
module tb_fft_issue_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, in_ready;
    logic [31:0] in_re, in_im;
    logic        bf_issue, bf_is_mj;
    logic [2:0]  bf_a_now, bf_b_now;
    logic [31:0] bf_ar, bf_ai, bf_br, bf_bi, bf_w_re, bf_w_im;
    logic        bf_wb_valid;
    logic [2:0]  bf_wb_addr_a, bf_wb_addr_b;
    logic [31:0] bf_wb_re_a, bf_wb_im_a, bf_wb_re_b, bf_wb_im_b;
    logic        out_valid, out_ready;
    logic [2:0]  out_idx;
    logic [31:0] out_re, out_im;
    logic        busy, done, err;

    fft_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .bf_issue(bf_issue), .bf_a_now(bf_a_now), .bf_b_now(bf_b_now),
        .bf_ar(bf_ar), .bf_ai(bf_ai), .bf_br(bf_br), .bf_bi(bf_bi),
        .bf_w_re(bf_w_re), .bf_w_im(bf_w_im), .bf_is_mj(bf_is_mj),
        .bf_wb_valid(bf_wb_valid), .bf_wb_addr_a(bf_wb_addr_a), .bf_wb_addr_b(bf_wb_addr_b),
        .bf_wb_re_a(bf_wb_re_a), .bf_wb_im_a(bf_wb_im_a),
        .bf_wb_re_b(bf_wb_re_b), .bf_wb_im_b(bf_wb_im_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_re(out_re), .out_im(out_im),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- fp32 <-> real (exact for the values used here) ----------
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'd0) return {d[63], 31'd0};
        e = e - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // ---------------- butterfly unit model ----------------
    typedef struct {
        logic [2:0]  a, b;
        logic [31:0] ra, ia, rb, ib;
        int          due;
        int          idx;
    } wb_t;

    wb_t q[$];
    int  cyc = 0, issue_cnt = 0, wb_cnt = 0, done_cnt = 0, deliver_limit = 1000;
    logic [2:0]  log_a [12];
    logic [2:0]  log_b [12];
    logic [31:0] log_wr[12];
    logic [31:0] log_wi[12];
    logic        log_mj[12];
    int          log_wb[12];

    always @(negedge clk) begin
        wb_t   e;
        real   ar, ai, br, bi, wr, wi, tr, ti;
        cyc++;
        if (done) done_cnt++;
        if (bf_issue) begin
            if (issue_cnt < 12) begin
                log_a[issue_cnt]  = bf_a_now;
                log_b[issue_cnt]  = bf_b_now;
                log_wr[issue_cnt] = bf_w_re;
                log_wi[issue_cnt] = bf_w_im;
                log_mj[issue_cnt] = bf_is_mj;
                log_wb[issue_cnt] = wb_cnt;
            end
            ar = f2r(bf_ar); ai = f2r(bf_ai); br = f2r(bf_br); bi = f2r(bf_bi);
            wr = f2r(bf_w_re); wi = f2r(bf_w_im);
            tr = br * wr - bi * wi;
            ti = br * wi + bi * wr;
            e.a = bf_a_now; e.b = bf_b_now;
            e.ra = r2f(ar + tr); e.ia = r2f(ai + ti);
            e.rb = r2f(ar - tr); e.ib = r2f(ai - ti);
            e.due = cyc + 2;
            e.idx = issue_cnt;
            q.push_back(e);
            issue_cnt++;
        end
        bf_wb_valid = 1'b0;
        if (q.size() > 0 && q[0].due <= cyc && q[0].idx < deliver_limit) begin
            e = q.pop_front();
            bf_wb_valid  = 1'b1;
            bf_wb_addr_a = e.a;  bf_wb_addr_b = e.b;
            bf_wb_re_a   = e.ra; bf_wb_im_a   = e.ia;
            bf_wb_re_b   = e.rb; bf_wb_im_b   = e.ib;
            wb_cnt++;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0][31:0] xr, xi, er, ei;
        int               stall_at;
    } vec_t;

    vec_t vecs[3];

    int          exp_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int          exp_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int          exp_t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    logic [31:0] twr[4]    = '{32'h3F800000, 32'h3F3504F3, 32'h00000000, 32'hBF3504F3};
    logic [31:0] twi[4]    = '{32'h00000000, 32'hBF3504F3, 32'hBF800000, 32'hBF3504F3};

    task automatic clear_frame();
        @(posedge clk);
        #1;
        q.delete();
        issue_cnt = 0;
        wb_cnt    = 0;
        done_cnt  = 0;
    endtask

    // Start pulse then 8 samples (with one bubble after x[3]); returns at a negedge.
    task automatic load_frame(input int vi, input string tag);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk(in_ready === 1'b1 && busy === 1'b1, {tag, "_load_ready"}, {in_ready, busy}, 2'b11);
        chk(err === 1'b0, {tag, "_err_clear_on_start"}, err, 0);
        for (int n = 0; n < 8; n++) begin
            in_valid = 1'b1; in_re = vecs[vi].xr[n]; in_im = vecs[vi].xi[n];
            @(negedge clk);
            if (n == 3) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int vi);
        string       tag;
        int          i, st;
        logic [2:0]  h_idx;
        logic [31:0] h_re, h_im;
        logic [31:0] w_r, w_i;
        tag = $sformatf("v%0d", vi);
        clear_frame();
        load_frame(vi, tag);
        i = 0; st = 0;
        for (int c = 0; c < 600 && i < 8; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                if (i == vecs[vi].stall_at && st < 5) begin
                    out_ready = 1'b0;
                    if (st == 0) begin
                        h_idx = out_idx; h_re = out_re; h_im = out_im;
                    end else begin
                        chk(out_idx === h_idx && out_re === h_re && out_im === h_im,
                            $sformatf("%s_stall_hold%0d", tag, st), {out_idx, out_re, out_im}, {h_idx, h_re, h_im});
                    end
                    st++;
                end else begin
                    out_ready = 1'b1;
                    chk(out_idx === 3'(i), $sformatf("%s_out_idx%0d", tag, i), out_idx, i);
                    chk(out_re === vecs[vi].er[i] && out_im === vecs[vi].ei[i],
                        $sformatf("%s_X%0d", tag, i), {out_re, out_im}, {vecs[vi].er[i], vecs[vi].ei[i]});
                    i++;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk(i == 8, {tag, "_out_count"}, i, 8);
        repeat (3) @(negedge clk);
        chk(done_cnt == 1, {tag, "_done_pulses"}, done_cnt, 1);
        chk(err === 1'b0 && busy === 1'b0, {tag, "_end_state"}, {err, busy}, 0);
        chk(issue_cnt == 12, {tag, "_issue_count"}, issue_cnt, 12);
        for (int j = 0; j < 12; j++) begin
            w_r = twr[exp_t[j]];
            w_i = twi[exp_t[j]];
            chk(log_a[j] === 3'(exp_a[j]) && log_b[j] === 3'(exp_b[j]) && log_wr[j] === w_r &&
                log_wi[j] === w_i && log_mj[j] === (exp_t[j] == 2),
                $sformatf("%s_issue%0d", tag, j), {log_a[j], log_b[j], log_wr[j], log_wi[j], log_mj[j]},
                {3'(exp_a[j]), 3'(exp_b[j]), w_r, w_i, 1'(exp_t[j] == 2)});
            chk(log_wb[j] >= 4 * (j / 4), $sformatf("%s_barrier%0d", tag, j), log_wb[j], 4 * (j / 4));
        end
    endtask

    initial begin
        int elapsed, bad;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
        bf_wb_valid = 1'b0; bf_wb_addr_a = '0; bf_wb_addr_b = '0;
        bf_wb_re_a = '0; bf_wb_im_a = '0; bf_wb_re_b = '0; bf_wb_im_b = '0;

        // impulse -> flat spectrum
        vecs[0].xr = '0; vecs[0].xi = '0; vecs[0].xr[0] = 32'h3F800000;
        for (int n = 0; n < 8; n++) begin
            vecs[0].er[n] = 32'h3F800000; vecs[0].ei[n] = '0;
        end
        vecs[0].stall_at = 99;
        // constant 1.0 -> DC bin 8.0; stalled at bin 3
        vecs[1].xi = '0; vecs[1].er = '0; vecs[1].ei = '0;
        for (int n = 0; n < 8; n++) vecs[1].xr[n] = 32'h3F800000;
        vecs[1].er[0] = 32'h41000000;
        vecs[1].stall_at = 3;
        // alternating +1/-1 -> Nyquist bin 4 = 8.0
        vecs[2].xi = '0; vecs[2].er = '0; vecs[2].ei = '0;
        for (int n = 0; n < 8; n++) vecs[2].xr[n] = (n % 2 == 0) ? 32'h3F800000 : 32'hBF800000;
        vecs[2].er[4] = 32'h41000000;
        vecs[2].stall_at = 99;

        // reset state
        repeat (2) @(negedge clk);
        chk({busy, in_ready, bf_issue, out_valid, done, err} === 6'b0, "reset_flags",
            {busy, in_ready, bf_issue, out_valid, done, err}, 0);
        chk({out_idx, out_re, out_im} === '0, "reset_out", {out_idx, out_re, out_im}, 0);
        chk({bf_a_now, bf_b_now, bf_ar, bf_w_re, bf_w_im, bf_is_mj} === '0, "reset_bf",
            {bf_a_now, bf_b_now, bf_ar, bf_w_re, bf_w_im, bf_is_mj}, 0);
        rst = 1'b0;

        for (int v = 0; v < 3; v++) run_frame(v);

        // drain timeout: butterfly never answers
        deliver_limit = 0;
        clear_frame();
        load_frame(1, "to");
        elapsed = 0;
        while (busy === 1'b1 && elapsed < 300) begin
            @(negedge clk);
            elapsed++;
        end
        chk(elapsed >= TIMEOUT && elapsed <= TIMEOUT + 10, "to_cycles", elapsed, TIMEOUT);
        chk(err === 1'b1 && busy === 1'b0, "to_err_idle", {err, busy}, 2'b10);
        chk(done_cnt == 0, "to_no_done", done_cnt, 0);
        chk(issue_cnt == 4, "to_issue_count", issue_cnt, 4);
        deliver_limit = 1000;
        run_frame(0);  // start must clear err; frame completes normally

        // reset during stage 1 drain
        deliver_limit = 4;
        clear_frame();
        load_frame(1, "rs");
        for (int c = 0; c < 300 && issue_cnt < 8; c++) begin
            @(negedge clk);
            #2;
        end
        chk(issue_cnt == 8, "rs_reach_stage1", issue_cnt, 8);
        rst = 1'b1;
        #1;
        chk({busy, bf_issue, out_valid, in_ready, done, err} === 6'b0, "rs_async_flags",
            {busy, bf_issue, out_valid, in_ready, done, err}, 0);
        chk({bf_a_now, bf_ar, bf_w_re, out_re, out_idx} === '0, "rs_async_data",
            {bf_a_now, bf_ar, bf_w_re, out_re, out_idx}, 0);
        @(negedge clk);
        rst = 1'b0;
        deliver_limit = 1000;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || bf_issue !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) bad++;
        end
        chk(wb_cnt == 8, "rs_stale_wb_sent", wb_cnt, 8);
        chk(bad == 0, "rs_stale_wb_ignored", bad, 0);
        run_frame(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
